// File: rtl/ofm_writeback_packer.sv
// Captures 16-channel PE pixel sets into a small FIFO and streams them to the OFM buffer as NHWC 32-bit words.
// Optional build macro OFM_WB_RELU_EN clamps negative bytes to zero before capture.
module ofm_writeback_packer #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [7:0]        OFM_W,
  input  logic [7:0]        OFM_C,
  input  logic [15:0]       valid,
  input  logic [7:0]        OFM_active_0,
  input  logic [7:0]        OFM_active_1,
  input  logic [7:0]        OFM_active_2,
  input  logic [7:0]        OFM_active_3,
  input  logic [7:0]        OFM_active_4,
  input  logic [7:0]        OFM_active_5,
  input  logic [7:0]        OFM_active_6,
  input  logic [7:0]        OFM_active_7,
  input  logic [7:0]        OFM_active_8,
  input  logic [7:0]        OFM_active_9,
  input  logic [7:0]        OFM_active_10,
  input  logic [7:0]        OFM_active_11,
  input  logic [7:0]        OFM_active_12,
  input  logic [7:0]        OFM_active_13,
  input  logic [7:0]        OFM_active_14,
  input  logic [7:0]        OFM_active_15,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_partial
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SET_W = 128;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [7:0]          w_m1;
  logic [3:0]          tiles_m1;
  logic [5:0]          step;
  logic [7:0]          col;
  logic [7:0]          row;
  logic [3:0]          tile;
  logic [ADDR_W-1:0]   pix_base;
  logic [ADDR_W-1:0]   tile_base;

  logic [SET_W-1:0]    mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [1:0]          word_idx;

  logic [SET_W-1:0]    raw_c;
  logic [SET_W-1:0]    set_c;
  logic                full_c;
  logic                fire_c;
  logic                pop_c;
  logic                arrive_c;
  logic                push_c;
  logic                drop_c;
  logic                partial_c;
  logic                cfg_ok_c;
  logic                last_c;
  logic [PTR_W-1:0]    next_ptr_c;
  logic                next_avail_c;

  // Word k of a set: channels 4k..4k+3, lowest channel in the top byte.
  function automatic logic [31:0] word_sel(input logic [SET_W-1:0] s, input logic [1:0] k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[8*(3-j) +: 8] = s[32*int'(k) + 8*j +: 8];
    end
    return w;
  endfunction

  assign raw_c = {OFM_active_15, OFM_active_14, OFM_active_13, OFM_active_12,
                  OFM_active_11, OFM_active_10, OFM_active_9,  OFM_active_8,
                  OFM_active_7,  OFM_active_6,  OFM_active_5,  OFM_active_4,
                  OFM_active_3,  OFM_active_2,  OFM_active_1,  OFM_active_0};

  always_comb begin
    set_c = raw_c;
`ifdef OFM_WB_RELU_EN
    for (int i = 0; i < 16; i++) begin
      if (raw_c[8*i+7]) set_c[8*i +: 8] = 8'h00;
    end
`endif
  end

  // Handshake, capture and serializer steering.
  always_comb begin
    full_c       = (count == CNT_W'(FIFO_DEPTH));
    fire_c       = wr_en && wr_ready;
    pop_c        = fire_c && (word_idx == 2'd3);
    arrive_c     = (state == RUN) && (valid == 16'hFFFF);
    push_c       = arrive_c && (!full_c || pop_c);
    drop_c       = arrive_c && full_c && !pop_c;
    partial_c    = (state == RUN) && (valid != 16'h0000) && (valid != 16'hFFFF);
    cfg_ok_c     = (OFM_C != 8'd0) && (OFM_C[3:0] == 4'd0) && (OFM_W != 8'd0);
    last_c       = (col == w_m1) && (row == w_m1) && (tile == tiles_m1);
    next_ptr_c   = wr_en ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    next_avail_c = wr_en ? (count > CNT_W'(1)) : (count != '0);
  end

  // Control FSM, set counters and incremental pixel address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      err_partial <= 1'b0;
      w_m1        <= '0;
      tiles_m1    <= '0;
      step        <= '0;
      col         <= '0;
      row         <= '0;
      tile        <= '0;
      pix_base    <= '0;
      tile_base   <= '0;
    end else begin
      done <= 1'b0;
      if (partial_c) err_partial <= 1'b1;
      if (drop_c)    overflow    <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            overflow    <= 1'b0;
            err_partial <= !cfg_ok_c;
            if (cfg_ok_c) begin
              state     <= RUN;
              busy      <= 1'b1;
              w_m1      <= OFM_W - 8'd1;
              tiles_m1  <= OFM_C[7:4] - 4'd1;
              step      <= OFM_C[7:2];
              col       <= '0;
              row       <= '0;
              tile      <= '0;
              pix_base  <= BASE;
              tile_base <= BASE;
            end
          end
        end
        RUN: begin
          if (arrive_c) begin
            if (col != w_m1) begin
              col      <= col + 8'd1;
              pix_base <= pix_base + ADDR_W'(step);
            end else if (row != w_m1) begin
              col      <= '0;
              row      <= row + 8'd1;
              pix_base <= pix_base + ADDR_W'(step);
            end else begin
              // Pixel index wraps: next tile starts 4 words further on.
              col       <= '0;
              row       <= '0;
              tile      <= tile + 4'd1;
              tile_base <= tile_base + ADDR_W'(4);
              pix_base  <= tile_base + ADDR_W'(4);
            end
            if (last_c) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == '0) || (pop_c && (count == CNT_W'(1)))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set storage; contents are meaningless until counted in by push.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_data[wr_ptr] <= set_c;
      mem_addr[wr_ptr] <= pix_base;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Serializer: registered write port, advances only when the current word is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      word_idx <= '0;
    end else if (!wr_en || fire_c) begin
      if (wr_en && (word_idx != 2'd3)) begin
        word_idx <= word_idx + 2'd1;
        wr_addr  <= wr_addr + ADDR_W'(1);
        wr_data  <= word_sel(mem_data[rd_ptr], word_idx + 2'd1);
      end else if (next_avail_c) begin
        wr_en    <= 1'b1;
        word_idx <= 2'd0;
        wr_addr  <= mem_addr[next_ptr_c];
        wr_data  <= word_sel(mem_data[next_ptr_c], 2'd0);
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Randomized bench for ofm_writeback_packer against a queue-based model of the NHWC write stream.
module tb_ofm_writeback_packer;

  localparam int DEPTH = 4;
  localparam int BASE  = 0;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } wexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic [7:0]  OFM_W;
  logic [7:0]  OFM_C;
  logic [15:0] valid;
  logic [7:0]  ch [16];
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        err_partial;

  int n_vec = 0;
  int n_err = 0;
  int ready_pct = 100;

  int    m_phase = P_IDLE;
  int    m_w, m_c, m_p, m_t, m_occ, m_word;
  bit    m_ovf, m_err;
  wexp_t exp_q [$];
  logic [19:0] got_addr [$];
  logic [31:0] got_data [$];
  int    dones;
  bit    stall_prev;
  logic [19:0] prev_addr;
  logic [31:0] prev_data;

  ofm_writeback_packer dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .OFM_W(OFM_W), .OFM_C(OFM_C),
    .valid(valid),
    .OFM_active_0(ch[0]),   .OFM_active_1(ch[1]),   .OFM_active_2(ch[2]),   .OFM_active_3(ch[3]),
    .OFM_active_4(ch[4]),   .OFM_active_5(ch[5]),   .OFM_active_6(ch[6]),   .OFM_active_7(ch[7]),
    .OFM_active_8(ch[8]),   .OFM_active_9(ch[9]),   .OFM_active_10(ch[10]), .OFM_active_11(ch[11]),
    .OFM_active_12(ch[12]), .OFM_active_13(ch[13]), .OFM_active_14(ch[14]), .OFM_active_15(ch[15]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .overflow(overflow), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef OFM_WB_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  always @(posedge clk) begin
    #2;
    wr_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Reference model: compares current outputs, then predicts the coming edge from sampled inputs.
  always @(negedge clk) begin : model
    bit    fire, pop;
    int    occ_before, npix;
    wexp_t e;
    if (!reset) begin
      m_phase = P_IDLE; m_occ = 0; m_word = 0; m_ovf = 0; m_err = 0;
      exp_q.delete(); stall_prev = 0;
    end else begin
      chk("busy", 64'(busy), 64'(m_phase != P_IDLE));
      chk("done", 64'(done), 64'(m_phase == P_DONE));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("err_partial", 64'(err_partial), 64'(m_err));
      if (done) dones++;
      if (stall_prev) begin
        chk("hold_en", 64'(wr_en), 64'(1));
        chk("hold_addr", 64'(wr_addr), 64'(prev_addr));
        chk("hold_data", 64'(wr_data), 64'(prev_data));
      end
      if (wr_en) begin
        chk("wr_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          chk("wr_addr", 64'(wr_addr), 64'(exp_q[0].addr));
          chk("wr_data", 64'(wr_data), 64'(exp_q[0].data));
        end
      end
      stall_prev = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;

      fire = wr_en && wr_ready;
      pop  = 0;
      if (fire) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_word++;
        if (m_word == 4) begin m_word = 0; pop = 1; end
      end
      occ_before = m_occ;
      if (pop) m_occ--;
      case (m_phase)
        P_IDLE: if (cfg_start) begin
          m_ovf = 0;
          if (OFM_C != 0 && (OFM_C % 16) == 0 && OFM_W != 0) begin
            m_err = 0; m_phase = P_RUN; m_w = int'(OFM_W); m_c = int'(OFM_C); m_p = 0; m_t = 0;
          end else m_err = 1;
        end
        P_RUN: begin
          if (valid == 16'hFFFF) begin
            npix = m_w * m_w;
            if (occ_before < DEPTH || pop) begin
              for (int k = 0; k < 4; k++) begin
                e.addr = 20'(BASE + m_p * (m_c / 4) + 4 * m_t + k);
                e.data = {relu(ch[4*k]), relu(ch[4*k+1]), relu(ch[4*k+2]), relu(ch[4*k+3])};
                exp_q.push_back(e);
              end
              m_occ++;
            end else m_ovf = 1;
            if (m_p == npix - 1 && m_t == m_c / 16 - 1) m_phase = P_DRAIN;
            m_p++;
            if (m_p == npix) begin m_p = 0; m_t++; end
          end else if (valid != 16'h0000) m_err = 1;
        end
        P_DRAIN: if (m_occ == 0) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int w, input int c);
    OFM_W = 8'(w); OFM_C = 8'(c); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_set(input bit ramp, input logic [15:0] v);
    for (int i = 0; i < 16; i++) ch[i] = ramp ? 8'(i) : 8'($urandom);
    valid = v;
    @(posedge clk); #1;
    valid = 16'h0000;
  endtask

  task automatic run_sets(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      send_set(1'b0, 16'hFFFF);
      gap(spacing - 1);
    end
  endtask

  task automatic wait_idle();
    bit timed_out = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (!busy && m_phase == P_IDLE) begin timed_out = 0; break; end
    end
    chk("idle_timeout", 64'(timed_out), 64'(0));
  endtask

  task automatic clear_logs();
    got_addr.delete(); got_data.delete(); dones = 0;
  endtask

  initial begin
    logic [31:0] t3_exp [4];
    int w, c, sp;
    t3_exp = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    reset = 1'b0; cfg_start = 1'b0; valid = '0; OFM_W = '0; OFM_C = '0; wr_ready = 1'b0;
    for (int i = 0; i < 16; i++) ch[i] = '0;
    dones = 0;
    gap(3);
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_flags", 64'({done, overflow, err_partial}), 64'(0));
    reset = 1'b1;
    gap(1);

    // Sets while idle are ignored; then 2x2x16 at one set per 8 cycles.
    clear_logs();
    send_set(1'b0, 16'hFFFF);
    gap(3);
    chk("idle_set_ignored", 64'(got_addr.size()), 64'(0));
    cfg(2, 16);
    send_set(1'b0, 16'hFFFF);
    chk("lat_e0", 64'(wr_en), 64'(0));
    gap(1);
    chk("lat_e1", 64'(wr_en), 64'(1));
    gap(6);
    for (int i = 0; i < 3; i++) begin send_set(1'b0, 16'hFFFF); gap(7); end
    wait_idle();
    chk("t1_writes", 64'(got_addr.size()), 64'(16));
    for (int i = 0; i < 16 && i < got_addr.size(); i++) chk("t1_addr", 64'(got_addr[i]), 64'(BASE + i));
    chk("t1_done", 64'(dones), 64'(1));

    // Two tiles: tile-major order interleaves addresses.
    clear_logs();
    cfg(2, 32);
    run_sets(8, 5);
    wait_idle();
    chk("t2_writes", 64'(got_addr.size()), 64'(32));
    if (got_addr.size() == 32) begin
      chk("t2_addr4", 64'(got_addr[4]), 64'(8));
      chk("t2_addr16", 64'(got_addr[16]), 64'(4));
      chk("t2_addr31", 64'(got_addr[31]), 64'(31));
    end

    // Byte packing with a channel ramp.
    clear_logs();
    cfg(1, 16);
    send_set(1'b1, 16'hFFFF);
    wait_idle();
    chk("t3_writes", 64'(got_data.size()), 64'(4));
    for (int i = 0; i < 4 && i < got_data.size(); i++) chk("t3_data", 64'(got_data[i]), 64'(t3_exp[i]));

    // Long stall: four sets held, the rest dropped.
    clear_logs();
    ready_pct = 0;
    cfg(3, 16);
    for (int i = 0; i < 9; i++) begin send_set(1'b0, 16'hFFFF); gap(3); end
    gap(4);
    chk("t4_ovf", 64'(overflow), 64'(1));
    chk("t4_no_wr", 64'(got_addr.size()), 64'(0));
    chk("t4_held_en", 64'(wr_en), 64'(1));
    ready_pct = 100;
    wait_idle();
    chk("t4_writes", 64'(got_addr.size()), 64'(16));
    if (got_addr.size() == 16) chk("t4_last_addr", 64'(got_addr[15]), 64'(15));
    chk("t4_done", 64'(dones), 64'(1));

    // Partial valid and bad channel count.
    clear_logs();
    cfg(1, 16);
    send_set(1'b0, 16'h00FF);
    chk("t5_err", 64'(err_partial), 64'(1));
    gap(4);
    chk("t5_no_wr", 64'(got_addr.size()), 64'(0));
    send_set(1'b0, 16'hFFFF);
    wait_idle();
    chk("t5_writes", 64'(got_addr.size()), 64'(4));
    cfg(2, 24);
    chk("t5_badcfg_err", 64'(err_partial), 64'(1));
    gap(3);
    chk("t5_badcfg_busy", 64'(busy), 64'(0));

    // Reset in DRAIN, then restart from the base address.
    clear_logs();
    ready_pct = 50;
    cfg(4, 32);
    run_sets(32, 1);
    ready_pct = 0;
    gap(2);
    chk("t6_busy_pre", 64'(busy), 64'(1));
    chk("t6_wr_en_pre", 64'(wr_en), 64'(1));
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t6_wr_en_rst", 64'(wr_en), 64'(0));
    chk("t6_busy_rst", 64'(busy), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    ready_pct = 100;
    clear_logs();
    cfg(1, 16);
    send_set(1'b0, 16'hFFFF);
    wait_idle();
    chk("t6_writes", 64'(got_addr.size()), 64'(4));
    if (got_addr.size() > 0) chk("t6_addr0", 64'(got_addr[0]), 64'(BASE));

    // Random geometries, spacing and backpressure.
    for (int r = 0; r < 6; r++) begin
      w  = $urandom_range(1, 3);
      c  = 16 * $urandom_range(1, 3);
      sp = $urandom_range(1, 6);
      ready_pct = $urandom_range(30, 100);
      clear_logs();
      cfg(w, c);
      run_sets(w * w * c / 16, sp);
      wait_idle();
      chk("rnd_done", 64'(dones), 64'(1));
      chk("rnd_exp_empty", 64'(exp_q.size()), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
